pc_unit: RTL

Parametrised program counter for the processor module, generalising the basic next/keep/load counter with PC-relative branches and a hardware return-address stack for call/return. Sits in the fetch stage and drives the instruction-memory address. Control logic selects one operation per cycle. The block registers the new PC on each rising clock edge.

---
 rtl/pc_unit_if.sv | 15 +
 rtl/pc_unit.sv | 63 ++++++
 2 files changed

// File: rtl/pc_unit_if.sv
// pc_unit_if: fetch-stage control/status bundle between sequencing logic and the program counter
interface pc_unit_if #(
    parameter int WORD_SIZE = 32,
    parameter int ADDR_SIZE = 14
);
    logic [2:0]           sel;
    logic [WORD_SIZE-1:0] instr;
    logic [WORD_SIZE-1:0] out;
    logic [ADDR_SIZE-1:0] addr;
    logic                 stack_empty;
    logic                 stack_full;
    logic                 err;
    modport master (output sel, instr, input out, addr, stack_empty, stack_full, err);
    modport slave  (input sel, instr, output out, addr, stack_empty, stack_full, err);
endinterface

// File: rtl/pc_unit.sv
// pc_unit: program counter with PC-relative branch and return-address stack for call/return
// Define PC_UNIT_TRAP_EN to redirect the PC to TRAP_ADDR on stack overflow/underflow.
module pc_unit #(
    parameter int                   WORD_SIZE   = 32,
    parameter int                   ADDR_SIZE   = 14,
    parameter int                   STACK_DEPTH = 8,
    parameter logic [WORD_SIZE-1:0] RESET_ADDR  = '0,
    parameter logic [WORD_SIZE-1:0] TRAP_ADDR   = 'h4
) (
    input logic        clk,
    input logic        rst,
    pc_unit_if.slave   bus
);
    typedef enum logic [2:0] {NEXT, KEEP, LOAD, BRANCH, CALL, RET} op_e;
    localparam int SPW = $clog2(STACK_DEPTH + 1);
    localparam int IW  = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;
`ifdef PC_UNIT_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    logic [WORD_SIZE-1:0] pc, pc_inc, pc_next, fault_pc;
    logic [WORD_SIZE-1:0] stack [2**IW];
    logic [SPW-1:0]       sp, top;
    logic                 err, empty, full, fault, push, pop;
    assign empty = sp == '0;
    assign full  = sp == SPW'(STACK_DEPTH);
    always_comb begin
        pc_inc   = pc + WORD_SIZE'(1);
        top      = sp - SPW'(1);
        push     = bus.sel == CALL && !full;
        pop      = bus.sel == RET && !empty;
        fault    = (bus.sel == CALL && full) || (bus.sel == RET && empty);
        // without trapping, an overflowing CALL still jumps and an underflowing RET holds
        fault_pc = TRAP_EN ? TRAP_ADDR : bus.sel == CALL ? bus.instr : pc;
        pc_next  = fault                 ? fault_pc :
                   bus.sel == NEXT       ? pc_inc :
                   bus.sel == LOAD       ? bus.instr :
                   bus.sel == BRANCH     ? pc + bus.instr :
                   bus.sel == CALL       ? bus.instr :
                   bus.sel == RET        ? stack[top[IW-1:0]] : pc;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pc  <= RESET_ADDR;
            sp  <= '0;
            err <= 1'b0;
        end else begin
            pc <= pc_next;
            if (fault) err <= 1'b1;
            if (push) sp <= sp + SPW'(1);
            if (pop) sp <= top;
        end
    end
    always_ff @(posedge clk) begin
        if (push) stack[sp[IW-1:0]] <= pc_inc;
    end
    assign bus.out         = pc;
    assign bus.addr        = pc[ADDR_SIZE-1:0];
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;
    assign bus.err         = err;
endmodule
